// File: rtl/fb_pixel_sink.sv
// Pixel sink: queues on-screen pixels from the game datapath and writes them into a linear framebuffer.
// Optional full-frame fill is compiled in with FB_PIXEL_SINK_CLEAR_EN.
module fb_pixel_sink #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned XRES       = 160,
    parameter int unsigned YRES       = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [23:0] colour,
    input  logic        writeEn,
    input  logic        clear_req,
    input  logic [23:0] clear_colour,
    input  logic        mem_grant,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [23:0] mem_data,
    output logic        full,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic        clear_done
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 24;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [8:0]       XRES_LIM  = 9'(XRES);
    localparam logic [8:0]       YRES_LIM  = 9'(YRES);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pixelEntry_t;

`ifdef FB_PIXEL_SINK_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(XRES * YRES - 1);
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
    typedef enum logic {IDLE, WRITE} state_t;
`endif

    state_t            state, stateNext;
    pixelEntry_t       fifoMem [FIFO_DEPTH];
    pixelEntry_t       pushEntry;
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [CNT_W-1:0]  occ, occNext;
    logic [ADDR_W-1:0] pixAddr;
    logic              onScreen, push, pop;
    logic              memWeNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memDataNext;

    // Linear address; the 160-wide case is two shifts and an add
    if (XRES == 160) begin : gAddrShift
        always_comb pixAddr = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    end else begin : gAddrMul
        always_comb pixAddr = ADDR_W'(ADDR_W'(y) * ADDR_W'(XRES)) + ADDR_W'(x);
    end

    assign onScreen       = ({1'b0, x} < XRES_LIM) && ({1'b0, y} < YRES_LIM);
    assign push           = writeEn && onScreen && !full;
    assign pushEntry.addr = pixAddr;
    assign pushEntry.data = colour;
    assign occNext        = occ + CNT_W'(push) - CNT_W'(pop);

`ifdef FB_PIXEL_SINK_CLEAR_EN
    logic clearPending, pendingNext, clearDoneNext;
`else
    logic unusedClear;
    assign unusedClear = ^{clear_req, clear_colour};
    assign clear_done  = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        stateNext   = state;
        memWeNext   = mem_we;
        memAddrNext = mem_addr;
        memDataNext = mem_data;
        pop         = 1'b0;
`ifdef FB_PIXEL_SINK_CLEAR_EN
        clearDoneNext = 1'b0;
        pendingNext   = clearPending | clear_req;
`endif
        case (state)
            IDLE: begin
`ifdef FB_PIXEL_SINK_CLEAR_EN
                if (clearPending || clear_req) begin
                    stateNext   = CLEAR;
                    memWeNext   = 1'b1;
                    memAddrNext = '0;
                    memDataNext = clear_colour;
                    pendingNext = 1'b0;
                end else
`endif
                if (occ != '0) begin
                    stateNext   = WRITE;
                    memWeNext   = 1'b1;
                    memAddrNext = fifoMem[rdPtr].addr;
                    memDataNext = fifoMem[rdPtr].data;
                end
            end
            WRITE: begin
                // On accept, load the next head (or a same-cycle push) to keep one write per cycle
                if (mem_grant) begin
                    pop = 1'b1;
                    if (occ > CNT_W'(1)) begin
                        memAddrNext = fifoMem[rdPtr + PTR_W'(1)].addr;
                        memDataNext = fifoMem[rdPtr + PTR_W'(1)].data;
                    end else if (push) begin
                        memAddrNext = pushEntry.addr;
                        memDataNext = pushEntry.data;
                    end else begin
                        stateNext = IDLE;
                        memWeNext = 1'b0;
                    end
                end
            end
`ifdef FB_PIXEL_SINK_CLEAR_EN
            CLEAR: begin
                if (mem_grant) begin
                    if (mem_addr == LAST_ADDR) begin
                        stateNext     = IDLE;
                        memWeNext     = 1'b0;
                        clearDoneNext = 1'b1;
                    end else begin
                        memAddrNext = mem_addr + ADDR_W'(1);
                    end
                end
            end
`endif
            default: begin
                stateNext = IDLE;
                memWeNext = 1'b0;
            end
        endcase
    end

    // State and framebuffer port registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            state    <= stateNext;
            mem_we   <= memWeNext;
            mem_addr <= memAddrNext;
            mem_data <= memDataNext;
        end
    end

    // Queue pointers, occupancy and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            occ        <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            occ  <= occNext;
            full <= (occNext == DEPTH_CNT);
            if (writeEn && onScreen && full) overflow <= 1'b1;
            if (writeEn && !onScreen && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= pushEntry;
    end

`ifdef FB_PIXEL_SINK_CLEAR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clearPending <= 1'b0;
            clear_done   <= 1'b0;
        end else begin
            clearPending <= pendingNext;
            clear_done   <= clearDoneNext;
        end
    end
`endif

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Self-checking bench for fb_pixel_sink: scoreboard of expected framebuffer writes checked as they are granted.
module tb_fb_pixel_sink;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  x = '0;
    logic [7:0]  y = '0;
    logic [23:0] colour = '0;
    logic        writeEn = 1'b0;
    logic        clear_req = 1'b0;
    logic [23:0] clear_colour = '0;
    logic        mem_grant = 1'b0;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [23:0] mem_data;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clear_done;

    typedef struct packed {
        logic [14:0] addr;
        logic [23:0] data;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          writesSeen = 0;
    int          clearDoneSeen = 0;
    int          cycle = 0;
    int          firstAcc = -1;
    int          lastAcc = -1;
    logic        holdValid = 1'b0;
    logic [14:0] holdAddr = '0;
    logic [23:0] holdData = '0;

    fb_pixel_sink dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .clear_req(clear_req), .clear_colour(clear_colour), .mem_grant(mem_grant),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .full(full),
        .overflow(overflow), .drop_count(drop_count), .clear_done(clear_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Monitor: every granted write must match the scoreboard head; stalled writes must hold
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (clear_done) clearDoneSeen++;
            if (holdValid && mem_we) begin
                checks++;
                if (mem_addr !== holdAddr || mem_data !== holdData) begin
                    errors++;
                    $display("FAIL stall_hold: addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_data, holdAddr, holdData);
                end
            end
            holdValid = mem_we && !mem_grant;
            holdAddr  = mem_addr;
            holdData  = mem_data;
            if (mem_we && mem_grant) begin
                writesSeen++;
                if (firstAcc < 0) firstAcc = cycle;
                lastAcc = cycle;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: addr=%0d data=%h, required no write", mem_addr, mem_data);
                end else begin
                    e = expQ.pop_front();
                    if (mem_addr !== e.addr || mem_data !== e.data) begin
                        errors++;
                        $display("FAIL write_order: addr=%0d data=%h, required addr=%0d data=%h",
                                 mem_addr, mem_data, e.addr, e.data);
                    end
                end
            end
        end else begin
            holdValid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) step();
    endtask

    task automatic pushPixel(input logic [7:0] px, input logic [7:0] py, input logic [23:0] pc, input bit accept);
        x = px;
        y = py;
        colour = pc;
        writeEn = 1'b1;
        if (accept) expQ.push_back({15'(int'(py) * 160 + int'(px)), pc});
        step();
        writeEn = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int bound);
        int n = 0;
        while (expQ.size() != 0 && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d writes outstanding, required 0", name, expQ.size());
        end
        idleCycles(2);
    endtask

    task automatic test_reset();
        #3;
        checks += 7;
        if (mem_we !== 1'b0)      begin errors++; $display("FAIL reset_we: got %b required 0", mem_we); end
        if (mem_addr !== 15'd0)   begin errors++; $display("FAIL reset_addr: got %0d required 0", mem_addr); end
        if (mem_data !== 24'd0)   begin errors++; $display("FAIL reset_data: got %h required 0", mem_data); end
        if (full !== 1'b0)        begin errors++; $display("FAIL reset_full: got %b required 0", full); end
        if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        if (drop_count !== 8'd0)  begin errors++; $display("FAIL reset_drop: got %0d required 0", drop_count); end
        if (clear_done !== 1'b0)  begin errors++; $display("FAIL reset_clear_done: got %b required 0", clear_done); end
        idleCycles(2);
        reset = 1'b1;
        idleCycles(2);
    endtask

    task automatic test_single_write();
        int w0 = writesSeen;
        bit seen = 0;
        mem_grant = 1'b1;
        pushPixel(8'd5, 8'd2, 24'hFF0000, 1);
        for (int i = 0; i <= 2; i++) begin
            if (mem_we) begin
                seen = 1;
                break;
            end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL single_latency: mem_we low 2 cycles after push, required high");
        end else begin
            checks++;
            if (mem_addr !== 15'd325 || mem_data !== 24'hFF0000) begin
                errors++;
                $display("FAIL single_value: addr=%0d data=%h, required addr=325 data=ff0000", mem_addr, mem_data);
            end
        end
        waitDrain("single", 20);
        idleCycles(3);
        checks++;
        if (writesSeen - w0 !== 1) begin
            errors++;
            $display("FAIL single_count: %0d writes, required 1", writesSeen - w0);
        end
    endtask

    task automatic test_offscreen();
        int w0 = writesSeen;
        mem_grant = 1'b1;
        pushPixel(8'd160, 8'd0, 24'h111111, 0);
        pushPixel(8'd0, 8'd120, 24'h222222, 0);
        idleCycles(4);
        checks += 2;
        if (writesSeen - w0 !== 0) begin errors++; $display("FAIL offscreen_writes: %0d writes, required 0", writesSeen - w0); end
        if (drop_count !== 8'd2)   begin errors++; $display("FAIL offscreen_drop2: got %0d required 2", drop_count); end
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) pushPixel(8'($urandom_range(160, 255)), 8'($urandom_range(0, 255)), 24'($urandom), 0);
            else            pushPixel(8'($urandom_range(0, 255)), 8'($urandom_range(120, 255)), 24'($urandom), 0);
        end
        idleCycles(3);
        checks += 2;
        if (drop_count !== 8'd255) begin errors++; $display("FAIL offscreen_saturate: got %0d required 255", drop_count); end
        if (writesSeen - w0 !== 0) begin errors++; $display("FAIL offscreen_writes2: %0d writes, required 0", writesSeen - w0); end
    endtask

    task automatic test_overflow();
        int w0 = writesSeen;
        mem_grant = 1'b0;
        for (int i = 0; i < 9; i++)
            pushPixel(8'(i * 3), 8'(10 + i), 24'h100000 + 24'(i), i < 8);
        idleCycles(2);
        checks += 2;
        if (full !== 1'b1)     begin errors++; $display("FAIL overflow_full: got %b required 1", full); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b required 1", overflow); end
        mem_grant = 1'b1;
        waitDrain("overflow", 40);
        checks += 3;
        if (writesSeen - w0 !== 8) begin errors++; $display("FAIL overflow_count: %0d writes, required 8", writesSeen - w0); end
        if (full !== 1'b0)         begin errors++; $display("FAIL overflow_unfull: got %b required 0", full); end
        if (overflow !== 1'b1)     begin errors++; $display("FAIL overflow_sticky: got %b required 1", overflow); end
    endtask

    task automatic test_grant_toggle();
        int w0 = writesSeen;
        int n = 0;
        mem_grant = 1'b0;
        for (int i = 0; i < 5; i++)
            pushPixel(8'(150 - i), 8'(100 + i), 24'hA0A000 + 24'(i * 17), 1);
        while (expQ.size() != 0 && n < 40) begin
            mem_grant = ~mem_grant;
            step();
            n++;
        end
        mem_grant = 1'b1;
        waitDrain("toggle", 20);
        checks++;
        if (writesSeen - w0 !== 5) begin errors++; $display("FAIL toggle_count: %0d writes, required 5", writesSeen - w0); end
    endtask

    task automatic test_back_to_back();
        int w0 = writesSeen;
        mem_grant = 1'b1;
        firstAcc = -1;
        for (int i = 0; i < 6; i++)
            pushPixel(8'(20 + i), 8'(119 - i), 24'h00C000 + 24'(i), 1);
        waitDrain("b2b", 20);
        checks += 2;
        if (writesSeen - w0 !== 6)   begin errors++; $display("FAIL b2b_count: %0d writes, required 6", writesSeen - w0); end
        if (lastAcc - firstAcc !== 5) begin errors++; $display("FAIL b2b_rate: writes spread over %0d cycles, required 5", lastAcc - firstAcc); end
    endtask

`ifdef FB_PIXEL_SINK_CLEAR_EN
    task automatic test_clear();
        int w0 = writesSeen;
        int c0 = clearDoneSeen;
        mem_grant = 1'b1;
        clear_colour = 24'h000000;
        for (int i = 0; i < 19200; i++) expQ.push_back({15'(i), 24'h000000});
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        clear_colour = 24'hABCDEF;
        pushPixel(8'd7, 8'd7, 24'h00FF00, 1);
        pushPixel(8'd159, 8'd119, 24'h0000FF, 1);
        waitDrain("clear", 20000);
        idleCycles(5);
        checks += 2;
        if (clearDoneSeen - c0 !== 1)  begin errors++; $display("FAIL clear_done_pulses: %0d, required 1", clearDoneSeen - c0); end
        if (writesSeen - w0 !== 19202) begin errors++; $display("FAIL clear_count: %0d writes, required 19202", writesSeen - w0); end
    endtask

    task automatic test_clear_reset();
        int w0;
        int n = 0;
        mem_grant = 1'b1;
        clear_colour = 24'h000000;
        for (int i = 0; i < 19200; i++) expQ.push_back({15'(i), 24'h000000});
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        while (!(mem_we && mem_addr == 15'd1000) && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (!(mem_we && mem_addr == 15'd1000)) begin
            errors++;
            $display("FAIL clear_reach_1000: addr=%0d we=%b, required addr=1000 we=1", mem_addr, mem_we);
        end
        #2;
        reset = 1'b0;
        #1;
        checks += 2;
        if (mem_we !== 1'b0)    begin errors++; $display("FAIL clear_reset_we: got %b required 0", mem_we); end
        if (mem_addr !== 15'd0) begin errors++; $display("FAIL clear_reset_addr: got %0d required 0", mem_addr); end
        expQ.delete();
        idleCycles(2);
        reset = 1'b1;
        w0 = writesSeen;
        idleCycles(50);
        checks += 2;
        if (writesSeen - w0 !== 0) begin errors++; $display("FAIL clear_reset_writes: %0d writes, required 0", writesSeen - w0); end
        if (mem_we !== 1'b0)       begin errors++; $display("FAIL clear_reset_idle: we=%b required 0", mem_we); end
    endtask
`else
    task automatic test_clear_ignored();
        int w0 = writesSeen;
        int c0 = clearDoneSeen;
        mem_grant = 1'b1;
        clear_colour = 24'h123456;
        clear_req = 1'b1;
        idleCycles(3);
        clear_req = 1'b0;
        idleCycles(5);
        checks += 3;
        if (writesSeen - w0 !== 0)  begin errors++; $display("FAIL noclear_writes: %0d writes, required 0", writesSeen - w0); end
        if (clearDoneSeen - c0 !== 0) begin errors++; $display("FAIL noclear_done: %0d pulses, required 0", clearDoneSeen - c0); end
        if (mem_we !== 1'b0)        begin errors++; $display("FAIL noclear_we: got %b required 0", mem_we); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_offscreen();
        test_overflow();
        test_grant_toggle();
        test_back_to_back();
`ifdef FB_PIXEL_SINK_CLEAR_EN
        test_clear();
        test_clear_reset();
`else
        test_clear_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
